mem_access_unit: RTL

- Memory-stage access controller between the pipeline's load/store path and the single-port-style data RAM (sync read, 1-cycle latency, read-over-write priority, word-addressed, no byte enables).
- Takes byte-addressed load/store requests and issues RAM read/write strobes.
- Returns sign- or zero-extended load data.
- Byte stores are done as read-modify-write, because the RAM has no byte enables.

---
 rtl/mem_access_unit.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
//------------------------------------------------------------------------------
// mem_access_unit: memory-stage load/store controller for a word-addressed
// sync-read RAM; byte stores use read-modify-write. Optional misaligned
// halfword trap enabled by defining MAU_MISALIGN_TRAP_EN.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_access_unit #(
  parameter int AWIDTH = 8,
  parameter int DWIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_we,
  input  logic              i_size,
  input  logic              i_unsigned,
  input  logic [AWIDTH:0]   i_addr,
  input  logic [DWIDTH-1:0] i_wdata,
  output logic              o_resp_valid,
  output logic [DWIDTH-1:0] o_rdata,
  output logic              o_ram_rd,
  output logic              o_ram_wr,
  output logic [AWIDTH-1:0] o_ram_raddr,
  output logic [AWIDTH-1:0] o_ram_waddr,
  output logic [DWIDTH-1:0] o_ram_wdata,
`ifdef MAU_MISALIGN_TRAP_EN
  output logic              o_err,
`endif
  input  logic [DWIDTH-1:0] i_ram_rdata
);

  localparam int C_BYTE = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LD_RD   = 3'd1,
    LD_CAP  = 3'd2,
    ST_WR   = 3'd3,
    RMW_RD  = 3'd4,
    RMW_MRG = 3'd5,
    RMW_WR  = 3'd6,
    RESP    = 3'd7
  } state_t;

  state_t              state_q, state_d;
  logic                size_q, size_d;
  logic                unsigned_q, unsigned_d;
  logic                lane_q, lane_d;
  logic [AWIDTH-1:0]   word_q, word_d;
  logic [C_BYTE-1:0]   byte_q, byte_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic [AWIDTH-1:0]   raddr_q, raddr_d;
  logic [AWIDTH-1:0]   waddr_q, waddr_d;
  logic [DWIDTH-1:0]   ramwdata_q, ramwdata_d;
  logic                resp_q, resp_d;
  logic [DWIDTH-1:0]   rdata_q, rdata_d;
`ifdef MAU_MISALIGN_TRAP_EN
  logic                err_q, err_d;
`endif

  logic [C_BYTE-1:0]   w_lane_byte;
  logic [DWIDTH-1:0]   w_load_ext;
  logic [DWIDTH-1:0]   w_merged;
  logic                w_misalign;

  assign w_lane_byte = lane_q ? i_ram_rdata[DWIDTH-1:C_BYTE] : i_ram_rdata[C_BYTE-1:0];
  assign w_load_ext  = size_q     ? i_ram_rdata :
                       unsigned_q ? {{(DWIDTH-C_BYTE){1'b0}}, w_lane_byte} :
                                    {{(DWIDTH-C_BYTE){w_lane_byte[C_BYTE-1]}}, w_lane_byte};
  assign w_merged    = lane_q ? {byte_q, i_ram_rdata[C_BYTE-1:0]}
                              : {i_ram_rdata[DWIDTH-1:C_BYTE], byte_q};

`ifdef MAU_MISALIGN_TRAP_EN
  assign w_misalign = i_size & i_addr[0];
`else
  assign w_misalign = 1'b0;
`endif

  assign o_req_ready = (state_q == IDLE);

  always_comb begin
    state_d    = state_q;
    size_d     = size_q;
    unsigned_d = unsigned_q;
    lane_d     = lane_q;
    word_d     = word_q;
    byte_d     = byte_q;
    rd_d       = 1'b0;
    wr_d       = 1'b0;
    raddr_d    = raddr_q;
    waddr_d    = waddr_q;
    ramwdata_d = ramwdata_q;
    resp_d     = 1'b0;
    rdata_d    = rdata_q;
`ifdef MAU_MISALIGN_TRAP_EN
    err_d      = 1'b0;
`endif
    // Strobes are registered, so each is raised on the edge entering its state.
    case (state_q)
      IDLE: begin
        if (i_req_valid) begin
          size_d     = i_size;
          unsigned_d = i_unsigned;
          lane_d     = i_addr[0];
          word_d     = i_addr[AWIDTH:1];
          byte_d     = i_wdata[C_BYTE-1:0];
          if (w_misalign) begin
            state_d = RESP;
            resp_d  = 1'b1;
`ifdef MAU_MISALIGN_TRAP_EN
            err_d   = 1'b1;
`endif
          end else if (i_we && i_size) begin
            state_d    = ST_WR;
            wr_d       = 1'b1;
            waddr_d    = i_addr[AWIDTH:1];
            ramwdata_d = i_wdata;
          end else begin
            state_d = i_we ? RMW_RD : LD_RD;
            rd_d    = 1'b1;
            raddr_d = i_addr[AWIDTH:1];
          end
        end
      end
      LD_RD:   state_d = LD_CAP;
      LD_CAP: begin
        rdata_d = w_load_ext;
        resp_d  = 1'b1;
        state_d = RESP;
      end
      ST_WR: begin
        resp_d  = 1'b1;
        state_d = RESP;
      end
      RMW_RD:  state_d = RMW_MRG;
      RMW_MRG: begin
        ramwdata_d = w_merged;
        waddr_d    = word_q;
        wr_d       = 1'b1;
        state_d    = RMW_WR;
      end
      RMW_WR: begin
        resp_d  = 1'b1;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      size_q     <= 1'b0;
      unsigned_q <= 1'b0;
      lane_q     <= 1'b0;
      word_q     <= '0;
      byte_q     <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      raddr_q    <= '0;
      waddr_q    <= '0;
      ramwdata_q <= '0;
      resp_q     <= 1'b0;
      rdata_q    <= '0;
`ifdef MAU_MISALIGN_TRAP_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      size_q     <= size_d;
      unsigned_q <= unsigned_d;
      lane_q     <= lane_d;
      word_q     <= word_d;
      byte_q     <= byte_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      raddr_q    <= raddr_d;
      waddr_q    <= waddr_d;
      ramwdata_q <= ramwdata_d;
      resp_q     <= resp_d;
      rdata_q    <= rdata_d;
`ifdef MAU_MISALIGN_TRAP_EN
      err_q      <= err_d;
`endif
    end
  end

  assign o_resp_valid = resp_q;
  assign o_rdata      = rdata_q;
  assign o_ram_rd     = rd_q;
  assign o_ram_wr     = wr_q;
  assign o_ram_raddr  = raddr_q;
  assign o_ram_waddr  = waddr_q;
  assign o_ram_wdata  = ramwdata_q;
`ifdef MAU_MISALIGN_TRAP_EN
  assign o_err        = err_q;
`endif

endmodule

`default_nettype wire
